// File: rtl/gam_weight_updater.sv
// rtl/gam_weight_updater.sv - GAM winner write-back: w_new = w + ((x - w) >>> shift), LANES elements per cycle
// Optional round-half-up step when GAM_UPDATE_ROUND_EN is defined.
package GAM_package;
  localparam int VECTOR_LEN = 4;
  typedef logic [VECTOR_LEN*8-1:0] node_vector_T;
endpackage

module gam_weight_updater
  import GAM_package::*;
#(
  parameter int LANES   = 1,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  node_vector_T       x,
  input  node_vector_T       w,
  input  logic [SHIFT_W-1:0] shift,
  output logic               busy,
  output logic               done_valid,
  input  logic               done_ready,
  output node_vector_T       w_new,
  output logic               changed
);

  localparam int IDX_W = $clog2(VECTOR_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VECTOR_LEN - LANES);
  localparam logic [IDX_W-1:0] LANE_STEP = IDX_W'(LANES);

  generate
    if (LANES < 1 || (VECTOR_LEN % LANES) != 0) begin : g_bad_lanes
      $error("gam_weight_updater: VECTOR_LEN must be divisible by LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  node_vector_T       x_q;
  node_vector_T       w_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [IDX_W-1:0]   index;
  node_vector_T       w_new_next;
  logic               changed_next;
  logic               accept;
  logic               last_group;

  // One element update; the result always lands between w and x, so 8-bit truncation is exact.
  function automatic logic [7:0] update_elem(input logic [7:0]         xe,
                                             input logic [7:0]         we,
                                             input logic [SHIFT_W-1:0] sh);
    logic signed [8:0] delta;
    logic [7:0]        step;
`ifdef GAM_UPDATE_ROUND_EN
    logic signed [9:0] biased;
`endif
    delta = $signed({1'b0, xe}) - $signed({1'b0, we});
`ifdef GAM_UPDATE_ROUND_EN
    biased = '0;
    if (sh == '0) begin
      step = delta[7:0];
    end else if (int'(sh) > 8) begin
      // |delta| < 2^8 <= 2^(sh-1): the biased value sits in [0, 2^sh) and floors to zero.
      step = '0;
    end else begin
      biased = {delta[8], delta} + (10'sd1 <<< (int'(sh) - 1));
      step   = 8'(biased >>> sh);
    end
`else
    step = 8'(delta >>> sh);
`endif
    return we + step;
  endfunction

  assign accept     = start_valid && start_ready;
  assign last_group = (index == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_group) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    int         elem;
    logic [7:0] upd;
    elem         = 0;
    upd          = '0;
    w_new_next   = w_new;
    changed_next = changed;
    for (int l = 0; l < LANES; l++) begin
      elem = int'(index) + l;
      upd  = update_elem(x_q[elem*8 +: 8], w_q[elem*8 +: 8], shift_q);
      w_new_next[elem*8 +: 8] = upd;
      if (upd != w_q[elem*8 +: 8]) changed_next = 1'b1;
    end
  end

  // Index wraps to zero after the last group so lane addressing never leaves the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      w_q     <= '0;
      shift_q <= '0;
      index   <= '0;
      w_new   <= '0;
      changed <= 1'b0;
    end else if (accept) begin
      x_q     <= x;
      w_q     <= w;
      shift_q <= shift;
      index   <= '0;
      w_new   <= '0;
      changed <= 1'b0;
    end else if (state == RUN) begin
      w_new   <= w_new_next;
      changed <= changed_next;
      index   <= last_group ? '0 : index + LANE_STEP;
    end
  end

endmodule

// File: tb/tb_gam_weight_updater.sv
// tb/tb_gam_weight_updater.sv - self-checking bench for gam_weight_updater (LANES=1 and LANES=2 instances)
module tb_gam_weight_updater;
  import GAM_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_valid, start_ready, busy, done_valid, done_ready, changed;
  node_vector_T x, w, w_new;
  logic [3:0]   shift;

  logic         start_valid2, start_ready2, busy2, done_valid2, done_ready2, changed2;
  node_vector_T x2, w2, w_new2;
  logic [3:0]   shift2;

  int passed = 0;
  int total  = 0;

  gam_weight_updater #(.LANES(1), .SHIFT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .x(x), .w(w), .shift(shift), .busy(busy), .done_valid(done_valid),
    .done_ready(done_ready), .w_new(w_new), .changed(changed)
  );

  gam_weight_updater #(.LANES(2), .SHIFT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid2), .start_ready(start_ready2),
    .x(x2), .w(w2), .shift(shift2), .busy(busy2), .done_valid(done_valid2),
    .done_ready(done_ready2), .w_new(w_new2), .changed(changed2)
  );

  // Reference: step = floor((x - w [+ 2^(sh-1)]) / 2^sh), computed with integer division.
  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic logic [7:0] model_elem(input logic [7:0] xe, input logic [7:0] we, input int sh);
    int d;
    int step;
    d = int'(xe) - int'(we);
`ifdef GAM_UPDATE_ROUND_EN
    if (sh > 0) d = d + (1 << (sh - 1));
`endif
    step = floor_div(d, 1 << sh);
    return 8'((int'(we) + step) & 255);
  endfunction

  function automatic node_vector_T model_vec(input node_vector_T xv, input node_vector_T wv, input int sh);
    node_vector_T r;
    r = '0;
    for (int i = 0; i < VECTOR_LEN; i++) r[i*8 +: 8] = model_elem(xv[i*8 +: 8], wv[i*8 +: 8], sh);
    return r;
  endfunction

  function automatic node_vector_T fill_vec(input logic [7:0] v);
    node_vector_T r;
    for (int i = 0; i < VECTOR_LEN; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic node_vector_T rand_vec();
    node_vector_T r;
    for (int i = 0; i < VECTOR_LEN; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic run_req(input node_vector_T xi, input node_vector_T wi, input int sh, output int lat);
    x = xi; w = wi; shift = 4'(sh); start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (done_valid !== 1'b1) $display("FAIL req_timeout: done_valid=%b after %0d cycles, required 1", done_valid, lat);
    else passed++;
  endtask

  task automatic finish_req();
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({start_ready, busy, done_valid, changed} !== 4'b1000)
      $display("FAIL reset_flags: got rdy/busy/dv/chg=%b required 1000", {start_ready, busy, done_valid, changed});
    else passed++;
    total++;
    if (w_new !== '0) $display("FAIL reset_w_new: got %h required 0", w_new);
    else passed++;
    total++;
    if ({start_ready2, busy2, done_valid2, w_new2} !== {3'b100, 32'h0})
      $display("FAIL reset_lanes2: got rdy=%b busy=%b dv=%b w_new=%h", start_ready2, busy2, done_valid2, w_new2);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    node_vector_T xr, wr;
    int lat;
    xr = rand_vec(); wr = rand_vec();
    x = xr; w = wr; shift = 4'd1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) $display("FAIL midrun_busy: got %b required 1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({start_ready, busy, done_valid, changed, w_new} !== {4'b1000, 32'h0})
      $display("FAIL midrun_async_reset: got rdy=%b busy=%b dv=%b chg=%b w_new=%h", start_ready, busy, done_valid, changed, w_new);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({start_ready, busy, done_valid, w_new} !== {3'b100, 32'h0})
      $display("FAIL midrun_release: got rdy=%b busy=%b dv=%b w_new=%h", start_ready, busy, done_valid, w_new);
    else passed++;
    xr = rand_vec(); wr = rand_vec();
    run_req(xr, wr, 3, lat);
    total++;
    if (w_new !== model_vec(xr, wr, 3)) $display("FAIL midrun_fresh: got %h required %h", w_new, model_vec(xr, wr, 3));
    else passed++;
    finish_req();
  endtask

  task automatic test_normal();
    int lat;
    run_req(fill_vec(8'd200), fill_vec(8'd100), 2, lat);
    total++;
    if (lat != VECTOR_LEN + 1) $display("FAIL normal_latency: got %0d required %0d", lat, VECTOR_LEN + 1);
    else passed++;
    total++;
    if (w_new !== fill_vec(8'd125)) $display("FAIL normal_w_new: got %h required %h", w_new, fill_vec(8'd125));
    else passed++;
    total++;
    if (changed !== 1'b1) $display("FAIL normal_changed: got %b required 1", changed);
    else passed++;
    finish_req();
  endtask

  task automatic test_negative_floor();
    int lat;
    logic [7:0]   e;
    logic         exp_chg;
`ifdef GAM_UPDATE_ROUND_EN
    e = 8'd11; exp_chg = 1'b0;
`else
    e = 8'd10; exp_chg = 1'b1;
`endif
    run_req(fill_vec(8'd10), fill_vec(8'd11), 1, lat);
    total++;
    if (w_new !== fill_vec(e)) $display("FAIL neg_w_new: got %h required %h", w_new, fill_vec(e));
    else passed++;
    total++;
    if (changed !== exp_chg) $display("FAIL neg_changed: got %b required %b", changed, exp_chg);
    else passed++;
    finish_req();
  endtask

  task automatic test_identity_shift0();
    int lat;
    node_vector_T v;
    v = rand_vec();
    run_req(v, v, 3, lat);
    total++;
    if ({w_new, changed} !== {v, 1'b0}) $display("FAIL identity: got w_new=%h chg=%b required %h 0", w_new, changed, v);
    else passed++;
    finish_req();
    run_req(fill_vec(8'd255), fill_vec(8'd0), 0, lat);
    total++;
    if (w_new !== fill_vec(8'd255)) $display("FAIL shift0: got %h required %h", w_new, fill_vec(8'd255));
    else passed++;
    finish_req();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    node_vector_T xr, wr, exp;
    xr = rand_vec(); wr = rand_vec(); exp = model_vec(xr, wr, 2);
    run_req(xr, wr, 2, lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      x = rand_vec(); w = rand_vec(); start_valid = c[0];
      @(posedge clk); #1;
      if (done_valid !== 1'b1 || w_new !== exp || start_ready !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, required 0 (w_new=%h exp=%h)", bad, w_new, exp);
    else passed++;
    start_valid = 1'b1;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    total++;
    if ({done_valid, busy, start_ready} !== 3'b001)
      $display("FAIL bp_handshake: got dv/busy/rdy=%b required 001", {done_valid, busy, start_ready});
    else passed++;
    start_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, w_new} !== {1'b0, exp}) $display("FAIL bp_after: got busy=%b w_new=%h required 0 %h", busy, w_new, exp);
    else passed++;
  endtask

  task automatic test_random();
    int lat;
    int sh;
    node_vector_T xr, wr, exp;
    logic         exp_chg;
    for (int n = 0; n < 24; n++) begin
      xr = rand_vec();
      wr = ($urandom_range(0, 5) == 0) ? xr : rand_vec();
      sh = int'($urandom_range(0, 15));
      exp = model_vec(xr, wr, sh);
      exp_chg = (exp != wr);
      run_req(xr, wr, sh, lat);
      repeat ($urandom_range(0, 2)) begin
        x = rand_vec();
        @(posedge clk); #1;
      end
      total++;
      if ({w_new, changed} !== {exp, exp_chg})
        $display("FAIL random_%0d: sh=%0d got %h/%b required %h/%b", n, sh, w_new, changed, exp, exp_chg);
      else passed++;
      finish_req();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    node_vector_T xa, wa;
    xa = rand_vec(); wa = rand_vec();
    done_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      x = xa; w = wa; shift = 4'(n + 1); start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 1;
      while (!done_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (w_new !== model_vec(xa, wa, n + 1) || lat != VECTOR_LEN + 1)
        $display("FAIL b2b_%0d: got %h lat=%0d required %h lat=%0d", n, w_new, lat, model_vec(xa, wa, n + 1), VECTOR_LEN + 1);
      else passed++;
      @(posedge clk); #1;
    end
    done_ready = 1'b0;
  endtask

  task automatic test_lanes2();
    int lat;
    node_vector_T xv, wv, exp;
    xv = {8'd128, 8'd7, 8'd255, 8'd0};
    wv = {8'd64, 8'd7, 8'd0, 8'd255};
    exp = model_vec(xv, wv, 1);
    x2 = xv; w2 = wv; shift2 = 4'd1; start_valid2 = 1'b1;
    @(posedge clk); #1;
    start_valid2 = 1'b0;
    lat = 1;
    while (!done_valid2 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != VECTOR_LEN / 2 + 1) $display("FAIL lanes2_latency: got %0d required %0d", lat, VECTOR_LEN / 2 + 1);
    else passed++;
    total++;
    if (w_new2 !== exp) $display("FAIL lanes2_w_new: got %h required %h", w_new2, exp);
    else passed++;
`ifndef GAM_UPDATE_ROUND_EN
    total++;
    if (w_new2 !== {8'd96, 8'd7, 8'd127, 8'd127}) $display("FAIL lanes2_table: got %h required 60077f7f", w_new2);
    else passed++;
`endif
    done_ready2 = 1'b1;
    @(posedge clk); #1;
    done_ready2 = 1'b0;
    total++;
    if ({done_valid2, start_ready2} !== 2'b01) $display("FAIL lanes2_done: got dv/rdy=%b required 01", {done_valid2, start_ready2});
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0; done_ready = 1'b0; x = '0; w = '0; shift = '0;
    start_valid2 = 1'b0; done_ready2 = 1'b0; x2 = '0; w2 = '0; shift2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid_run();
    test_normal();
    test_negative_floor();
    test_identity_shift0();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_lanes2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gam_weight_updater.md
Name: gam_weight_updater

Overview:
- Inverse companion of the GAM distance path. The distance path reads x and w to produce a Euclidean distance. This block writes back: it moves the winning node's weight vector toward the input.
- Update per element: w_new[i] = w[i] + ((x[i] - w[i]) >>> shift).
- Element-serial (LANES elements per cycle) under a start/done valid-ready handshake.
- Sits between winner selection and the node memory write port.

Parameters:
- LANES, 1, elements processed per cycle; VECTOR_LEN (GAM_package) must be divisible by LANES; violation is an elaboration error.
- SHIFT_W, 4, width of the learning-rate shift input.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request valid.
- start_ready  output  1  block can accept a request.
- x  input  node_vector_T  input vector; 8-bit unsigned elements; element i at bits [(i*8)+7:i*8].
- w  input  node_vector_T  current weight vector of the winner, same layout.
- shift  input  SHIFT_W  learning rate; effective rate is 2^-shift.
- busy  output  1  high while in RUN or DONE.
- done_valid  output  1  w_new and changed are valid.
- done_ready  input  1  consumer accepts the result.
- w_new  output  node_vector_T  updated weight vector.
- changed  output  1  at least one element differs from w.

Behaviour:
- Reset (async, rst_n low) forces the following; reset mid-RUN or mid-DONE aborts and discards the request.
  - state = IDLE, start_ready = 1, busy = 0, done_valid = 0, changed = 0.
  - w_new = 0, element index = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready: register x, w and shift; clear w_new, changed and index; go to RUN.
  - Inputs are sampled only at acceptance; later changes are ignored.
- RUN:
  - start_ready = 0.
  - Each cycle, process elements index .. index+LANES-1 and write them into w_new.
  - OR any element mismatch into changed.
  - index += LANES.
  - After the group containing element VECTOR_LEN-1, go to DONE.
  - RUN lasts exactly VECTOR_LEN/LANES cycles.
- DONE:
  - done_valid = 1; w_new and changed are held stable.
  - On done_ready go to IDLE; done_valid falls the next cycle.
  - done_valid never drops without done_ready.
  - A new start is not accepted in the same cycle as the done handshake; start_ready rises in IDLE.
- Latency: acceptance edge to done_valid is VECTOR_LEN/LANES + 1 cycles.
- Arithmetic, per element:
  - delta = {1'b0,x[i]} - {1'b0,w[i]}, 9-bit signed.
  - step = delta >>> shift (arithmetic, floor).
  - w_new[i] = w[i] + step, truncated to 8 bits.
  - Result always lies in [min(x[i],w[i]), max(x[i],w[i])]; no saturation logic.
- Boundary rules:
  - shift = 0: w_new = x exactly.
  - shift >= 9: step is 0 for delta >= 0 and -1 for delta < 0 (floor).
  - x == w: w_new = w, changed = 0.
  - Registered shift is used for every element of the request.
- start_valid asserted while busy: ignored, not queued.

Optional Feature:
- Macro: GAM_UPDATE_ROUND_EN.
- Defined, and shift > 0: step = (delta + 2^(shift-1)) >>> shift, i.e. round half up; the range guarantee above still holds.
- Defined, and shift = 0: no addend.
- Not defined: floor behaviour as above; no rounding adder is present.

Test Plan:
- Reset mid-operation: drop rst_n two cycles into RUN, then release -> all outputs at reset values, state IDLE, start_ready = 1; a fresh request then completes normally.
- Normal update:
  - Stimulus: LANES=1, all x elements 200, all w elements 100, shift=2.
  - Required: done_valid exactly VECTOR_LEN+1 cycles after acceptance; every w_new element = 125; changed = 1.
- Negative delta, floor:
  - Stimulus: x=10, w=11 in all elements, shift=1.
  - Required: w_new = 10 everywhere.
  - With GAM_UPDATE_ROUND_EN: w_new = 11, changed = 0.
- Identity and shift=0:
  - x == w, shift=3 -> w_new = w, changed = 0.
  - Then x=255, w=0, shift=0 -> w_new = 255.
- Handshake backpressure:
  - Stimulus: hold done_ready = 0 for 5 cycles in DONE while toggling x and w.
  - Required: w_new and done_valid stable; start_valid pulses ignored; result unchanged after done_ready.
- LANES=2 variant:
  - Stimulus: mixed elements x = {0,255,7,128}, w = {255,0,7,64}, shift=1 (element 0 first).
  - Required: w_new = {127,127,7,96}; done_valid after VECTOR_LEN/2+1 cycles.
